// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory port between an instruction-fetch
// requester and a data requester, with starvation control and an access timeout.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_rd_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              m_enable,
    output logic              m_rd_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_busy
);

    localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic              gnt_i_q,      gnt_i_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
    logic              i_ack_q,      i_ack_d;
    logic              d_ack_q,      d_ack_d;
    logic              err_q,        err_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              m_enable_q,   m_enable_d;
    logic              m_rd_wr_q,    m_rd_wr_d;
    logic [1:0]        m_size_q,     m_size_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;

    logic starve_full;
    logic grant_i;
    logic tmo_last;

    assign starve_full = (starve_cnt_q == SC_W'(STARVE_MAX));
    assign tmo_last    = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    // Data wins ties unless the fetch side has already waited STARVE_MAX grants.
    assign grant_i     = i_req && (!d_req || starve_full);

    always_comb begin
        state_d      = state_q;
        gnt_i_d      = gnt_i_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        m_enable_d   = m_enable_q;
        m_rd_wr_d    = m_rd_wr_q;
        m_size_d     = m_size_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d    = ACCESS;
                    gnt_i_d    = grant_i;
                    tmo_cnt_d  = '0;
                    m_enable_d = 1'b1;
                    if (grant_i) begin
                        m_addr_d     = i_addr;
                        m_size_d     = 2'b10;
                        m_rd_wr_d    = 1'b1;
                        starve_cnt_d = '0;
                    end else begin
                        m_addr_d  = d_addr;
                        m_size_d  = d_size;
                        m_rd_wr_d = d_rd_wr;
                        m_wdata_d = d_wdata;
                        if (!i_req)
                            starve_cnt_d = '0;
                        else if (!starve_full)
                            starve_cnt_d = starve_cnt_q + SC_W'(1);
                    end
                end
            end

            ACCESS: begin
                if (!m_busy || tmo_last) begin
                    state_d    = RESP;
                    m_enable_d = 1'b0;
                    m_rd_wr_d  = 1'b1;
                    i_ack_d    = gnt_i_q;
                    d_ack_d    = !gnt_i_q;
                    err_d      = m_busy;
                    // Read data is only latched on a real completion, never on timeout or write.
                    if (!m_busy) begin
                        if (gnt_i_q)
                            i_rdata_d = m_rdata;
                        else if (m_rd_wr_q)
                            d_rdata_d = m_rdata;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                m_enable_d = 1'b0;
                m_rd_wr_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_i_q      <= 1'b0;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            m_enable_q   <= 1'b0;
            m_rd_wr_q    <= 1'b1;
            m_size_q     <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            gnt_i_q      <= gnt_i_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            m_enable_q   <= m_enable_d;
            m_rd_wr_q    <= m_rd_wr_d;
            m_size_q     <= m_size_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign i_ack    = i_ack_q;
    assign d_ack    = d_ack_q;
    assign err      = err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_enable = m_enable_q;
    assign m_rd_wr  = m_rd_wr_q;
    assign m_size   = m_size_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

endmodule
